// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler and busy scoreboard for a single-write-port register file.
// Round-robin arbitration between the ALU (0) and load unit (1), with RAW/WAW issue stall.
module regfile_wb_scheduler #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs1,
  input  logic [ADDR_W-1:0] issue_rs2,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W:0]   busy_count,
  output logic              wb_err
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_count_q, busy_count_d;
  logic              lg_q, lg_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic              wb_err_q, wb_err_d;
  logic              gnt0, gnt1, accept, issue_fire, wr_live;

  assign issue_ready = !(busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
  assign issue_fire  = issue_valid & issue_ready;
  assign wb0_ready   = gnt0;
  assign wb1_ready   = gnt1;
  assign accept      = gnt0 | gnt1;
  assign wr_live     = rf_we_q && (rf_waddr_q != '0);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (wb0_valid && wb1_valid) begin
      gnt1 = !lg_q;
      gnt0 = lg_q;
    end else begin
      gnt0 = wb0_valid;
      gnt1 = wb1_valid;
    end
  end

  // The in-flight write clears its bit at the edge the register file captures it;
  // a concurrent issue to a different register sets its bit at the same edge.
  always_comb begin
    busy_d = busy_q;
    if (wr_live) busy_d[rf_waddr_q] = 1'b0;
    if (issue_fire && (issue_rd != '0)) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    busy_count_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      busy_count_d = busy_count_d + {{ADDR_W{1'b0}}, busy_d[i]};

    wb_err_d   = wb_err_q | (wr_live && !busy_q[rf_waddr_q]);
    lg_d       = accept ? gnt1 : lg_q;
    rf_we_d    = accept;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (accept) begin
      rf_waddr_d = gnt1 ? wb1_rd   : wb0_rd;
      rf_wdata_d = gnt1 ? wb1_data : wb0_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
      lg_q         <= 1'b0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
      wb_err_q     <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      lg_q         <= lg_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      wb_err_q     <= wb_err_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign busy_count = busy_count_q;
  assign wb_err     = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: scoreboard model checked every cycle plus directed literal checks.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs1 = '0, issue_rs2 = '0, issue_rd = '0;
  logic        issue_ready;
  logic        wb0_valid = 1'b0, wb1_valid = 1'b0;
  logic [4:0]  wb0_rd = '0, wb1_rd = '0;
  logic [31:0] wb0_data = '0, wb1_data = '0;
  logic        wb0_ready, wb1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  busy_count;
  logic        wb_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  regfile_wb_scheduler #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_ready(issue_ready),
    .wb0_valid(wb0_valid), .wb0_rd(wb0_rd), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_rd(wb1_rd), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_count(busy_count), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: set of busy registers, the write in flight, and the round-robin owner.
  logic [31:0] m_busy = '0;
  logic        m_lg = 1'b0, m_we = 1'b0, m_err = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  function automatic int winner(input logic v0, input logic v1, input logic lg);
    if (v0 && v1) return lg ? 0 : 1;
    if (v1) return 1;
    if (v0) return 0;
    return -1;
  endfunction

  function automatic logic m_hazard(input logic [31:0] b, input logic [4:0] a, input logic [4:0] c,
                                    input logic [4:0] d);
    return b[a] || b[c] || b[d];
  endfunction

  function automatic logic [31:0] next_busy(input logic [31:0] b, input logic we, input logic [4:0] wa,
                                            input logic iv, input logic [4:0] a, input logic [4:0] c,
                                            input logic [4:0] d);
    logic [31:0] r;
    r = b;
    if (we && wa != 0) r[wa] = 1'b0;
    if (iv && !m_hazard(b, a, c, d) && d != 0) r[d] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= '0; m_lg <= 1'b0; m_we <= 1'b0; m_err <= 1'b0; m_waddr <= '0; m_wdata <= '0;
    end else begin
      m_busy <= next_busy(m_busy, m_we, m_waddr, issue_valid, issue_rs1, issue_rs2, issue_rd);
      if (m_we && m_waddr != 0 && !m_busy[m_waddr]) m_err <= 1'b1;
      m_we <= (winner(wb0_valid, wb1_valid, m_lg) >= 0);
      if (winner(wb0_valid, wb1_valid, m_lg) == 0) begin
        m_lg <= 1'b0; m_waddr <= wb0_rd; m_wdata <= wb0_data;
      end else if (winner(wb0_valid, wb1_valid, m_lg) == 1) begin
        m_lg <= 1'b1; m_waddr <= wb1_rd; m_wdata <= wb1_data;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("issue_ready", issue_ready, !m_hazard(m_busy, issue_rs1, issue_rs2, issue_rd));
      chk("wb0_ready", wb0_ready, winner(wb0_valid, wb1_valid, m_lg) == 0);
      chk("wb1_ready", wb1_ready, winner(wb0_valid, wb1_valid, m_lg) == 1);
      chk("rf_we", rf_we, m_we);
      if (m_we) begin
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("rf_wdata", rf_wdata, m_wdata);
      end
      chk("busy_count", busy_count, $countones(m_busy));
      chk("wb_err", wb_err, m_err);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int i0, i1;
    logic [4:0] seq [6];
    seq = '{5'd11, 5'd10, 5'd13, 5'd12, 5'd15, 5'd14};

    // Reset then idle
    #1 rst = 1'b1;
    #1 armed = 1'b1;
    cyc; cyc;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_busy_count", busy_count, 0);
    chk("rst_issue_ready", issue_ready, 1);
    rst = 1'b0;
    cyc;
    issue_rs1 = 5'd31; issue_rs2 = 5'd17; issue_rd = 5'd9;
    #1;
    chk("idle_issue_ready", issue_ready, 1);
    chk("idle_wb_err", wb_err, 0);
    chk("idle_rf_we", rf_we, 0);

    // RAW stall and release through write-back
    cyc;
    issue_valid = 1'b1; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 5'd5;
    cyc;
    issue_rs1 = 5'd5; issue_rd = 0;
    #1;
    chk("raw_stall", issue_ready, 0);
    chk("raw_count1", busy_count, 1);
    cyc;
    issue_valid = 1'b0;
    cyc;
    wb0_valid = 1'b1; wb0_rd = 5'd5; wb0_data = 32'hDEADBEEF;
    #1 chk("raw_wb0_ready", wb0_ready, 1);
    cyc;
    wb0_valid = 1'b0;
    #1;
    chk("raw_rf_we", rf_we, 1);
    chk("raw_waddr", rf_waddr, 5);
    chk("raw_wdata", rf_wdata, 32'hDEADBEEF);
    chk("raw_still_stalled", issue_ready, 0);
    cyc;
    #1;
    chk("raw_released", issue_ready, 1);
    chk("raw_count0", busy_count, 0);
    issue_rs1 = 0;

    // Simultaneous requests right after reset: wb1 first
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    cyc;
    issue_rd = 5'd4;
    cyc;
    issue_valid = 1'b0; issue_rd = 0;
    wb0_valid = 1'b1; wb0_rd = 5'd3; wb0_data = 32'h33;
    wb1_valid = 1'b1; wb1_rd = 5'd4; wb1_data = 32'h44;
    #1;
    chk("rr_first_wb1", wb1_ready, 1);
    chk("rr_first_wb0", wb0_ready, 0);
    cyc;
    wb1_valid = 1'b0;
    #1;
    chk("rr_second_wb0", wb0_ready, 1);
    chk("rr_waddr_4", rf_waddr, 4);
    chk("rr_wdata_44", rf_wdata, 32'h44);
    cyc;
    wb0_valid = 1'b0;
    #1;
    chk("rr_waddr_3", rf_waddr, 3);
    chk("rr_count_mid", busy_count, 1);
    cyc;
    #1 chk("rr_count_end", busy_count, 0);

    // Continuous dual requests alternate every cycle
    issue_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue_rd = 5'(10 + i);
      cyc;
    end
    issue_valid = 1'b0; issue_rd = 0;
    #1 chk("alt_count6", busy_count, 6);
    i0 = 0; i1 = 0;
    for (int k = 0; k < 6; k++) begin
      wb0_valid = 1'b1; wb0_rd = 5'(10 + 2 * i0); wb0_data = 32'hA000 + 32'(10 + 2 * i0);
      wb1_valid = 1'b1; wb1_rd = 5'(11 + 2 * i1); wb1_data = 32'hA000 + 32'(11 + 2 * i1);
      #1;
      chk("alt_grant1", wb1_ready, (k % 2) == 0);
      if (k > 0) chk("alt_waddr", rf_waddr, seq[k-1]);
      if (wb1_ready) i1++; else i0++;
      cyc;
    end
    wb0_valid = 1'b0; wb1_valid = 1'b0;
    #1;
    chk("alt_waddr_last", rf_waddr, seq[5]);
    chk("alt_count1", busy_count, 1);
    cyc;
    #1 chk("alt_count0", busy_count, 0);

    // Write-back to a non-busy register, then to r0
    wb0_valid = 1'b1; wb0_rd = 5'd9; wb0_data = 32'h99;
    cyc;
    wb0_valid = 1'b0;
    #1 chk("err_rf_we9", rf_waddr, 9);
    cyc;
    #1 chk("err_set", wb_err, 1);
    wb1_valid = 1'b1; wb1_rd = 5'd0; wb1_data = 32'h5;
    cyc;
    wb1_valid = 1'b0;
    #1;
    chk("r0_rf_we", rf_we, 1);
    chk("r0_waddr", rf_waddr, 0);
    cyc;
    #1;
    chk("err_sticky", wb_err, 1);
    chk("r0_count", busy_count, 0);

    // Reset during the rf_we cycle discards the write
    issue_valid = 1'b1; issue_rd = 5'd7;
    cyc;
    issue_valid = 1'b0; issue_rd = 0; issue_rs1 = 5'd7;
    wb0_valid = 1'b1; wb0_rd = 5'd7; wb0_data = 32'h77;
    cyc;
    wb0_valid = 1'b0;
    #1;
    chk("mid_rf_we_before", rf_we, 1);
    chk("mid_stall_before", issue_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rf_we", rf_we, 0);
    chk("mid_count", busy_count, 0);
    chk("mid_ready", issue_ready, 1);
    chk("mid_err", wb_err, 0);
    cyc; cyc;
    rst = 1'b0;
    cyc;
    #1;
    chk("post_rf_we", rf_we, 0);
    chk("post_count", busy_count, 0);
    cyc; cyc;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Write-back scheduler and scoreboard for the 32×32 register file, which has one write port and asynchronous reads. It arbitrates two write-back requesters (ALU and load unit) onto the single write port with round-robin fairness. It tracks a per-register busy bitmap and stalls instruction issue on read-after-write and write-after-write hazards. It sits between the issue stage, the execution units and the register file's regWrite/writeRegister/writeData inputs.

## Interface
- DATA_W, 32, write-data width
- ADDR_W, 5, register index width; the register file depth is 2**ADDR_W
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  issue stage presents an instruction
- issue_rs1, issue_rs2, issue_rd  in  ADDR_W each  source and destination indices; index 0 means "unused/r0"
- issue_ready  out  1  instruction may issue this cycle
- wb0_valid, wb1_valid  in  1 each  write-back request from ALU (0) and load unit (1)
- wb0_rd, wb1_rd  in  ADDR_W each  destination index
- wb0_data, wb1_data  in  DATA_W each  result
- wb0_ready, wb1_ready  out  1 each  grant; the request is accepted when valid & ready
- rf_we  out  1  to register file regWrite
- rf_waddr  out  ADDR_W  to register file writeRegister
- rf_wdata  out  DATA_W  to register file writeData
- busy_count  out  ADDR_W+1  number of busy registers
- wb_err  out  1  sticky: a write-back targeted a non-busy, non-zero register

## Operation
- Scoreboard: busy[2**ADDR_W-1:0]. busy[0] is hardwired 0.
- Hazard: busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd].
- issue_ready = !hazard. It is combinational and does not depend on issue_valid.
- Issue fire = issue_valid & issue_ready. On fire with issue_rd != 0, busy[issue_rd] sets at the next edge.
- Arbitration: combinational, one grant per cycle, round-robin via a 1-bit last-grant pointer lg.
  - Only one valid: that requester is granted.
  - Both valid: grant requester 1 if lg == 0, else requester 0.
  - lg updates to the granted index on each accept and holds otherwise.
- Requesters hold valid, rd and data stable until accepted. wbN_ready never asserts without wbN_valid.
- Accepted request is registered: rf_we = 1, rf_waddr = rd, rf_wdata = data, all valid in the following cycle. rf_we = 0 in any cycle following a cycle with no accept.
- Busy clear: busy[rf_waddr] clears at the same edge at which the register file captures the write (the edge ending the rf_we cycle). The new value is readable from the register file in the cycle after.
- Write-back to rd = 0 is accepted and forwarded with rf_we = 1; the register file ignores it. It clears nothing and does not set wb_err.
- Write-back whose rd is not busy when it reaches rf_we: the write is still performed and wb_err sets (cleared only by rst).
- Simultaneous set (issue) and clear (rf write) on different registers at one edge: both take effect.
- Same register: cannot occur, because busy[rd] blocks issue until the clear edge.
- busy_count = popcount(busy). It is registered, consistent with busy after each edge, and reaches 2**ADDR_W-1 maximum.

## Timing
- Reset (async, immediate) values: busy = 0, busy_count = 0, lg = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, wb_err = 0. issue_ready = 1 while in reset.
- rst asserted mid-operation: all pending busy bits and any registered write in flight are discarded; no write reaches the register file after rst rises.
- Issue-to-ready latency for a dependent instruction, from write-back accept in cycle t:
  - t+1: rf_we high
  - busy clears at the end of t+1
  - t+2: dependent instruction sees issue_ready = 1 and reads the updated value
- Back-to-back accepts: one write per cycle sustained; with both requesters continuously valid, grants alternate every cycle.

## Test plan
- Reset then idle: busy_count = 0, issue_ready = 1 for any indices, rf_we = 0, wb_err = 0.
- Issue rd = 5 at t0; issue rs1 = 5 at t1 → issue_ready = 0. wb0 rd = 5, data = 0xDEADBEEF accepted at t3 → rf_we = 1, waddr = 5 at t4; issue_ready = 1 at t5; busy_count goes 1 → 0.
- Make 3, 4 busy; hold wb0 (rd 3) and wb1 (rd 4) valid together from reset → wb1 granted first (lg = 0), wb0 next cycle; rf_waddr sequence 4, 3.
- Both requesters continuously valid with fresh busy targets for 6 cycles → grants alternate 1, 0, 1, 0, 1, 0; one rf_we per cycle.
- Write-back rd = 9 with busy[9] = 0 → write performed, wb_err = 1 and stays 1. Write-back rd = 0 → rf_we = 1, wb_err unaffected.
- Issue rd = 7, accept wb rd = 7, assert rst in the rf_we cycle → rf_we = 0 immediately, busy_count = 0, issue_ready = 1.
